// File: rtl/instruction_queue.sv
// Circular FIFO between fetcher and decoder: holds instruction word, PC and BTB
// prediction, offers the head to the decoder, and is emptied in one cycle by ROB_clear.
module instruction_queue #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        IF_flag,
    input  logic [31:0] IF_inst,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_BTB_PC,
    input  logic        IF_BTB_predict,
    output logic        IQ_full,
    output logic        IQ_flag,
    output logic [31:0] IQ_inst,
    output logic [31:0] IQ_PC,
    output logic [31:0] IQ_BTB_PC,
    output logic        IQ_BTB_predict,
    input  logic        Dec_flag,
    input  logic        ROB_clear
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [31:0] inst_mem    [DEPTH];
    logic [31:0] pc_mem      [DEPTH];
    logic [31:0] btb_pc_mem  [DEPTH];
    logic        predict_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] tail;
    logic [ADDR_WIDTH:0]   count;

    logic push;
    logic pop;

    // Full is judged on count alone so the fetcher never sees it depend on a same-cycle pop.
    assign IQ_full = (count == FULL_COUNT);
    assign IQ_flag = rdy_in && !ROB_clear && (count != '0);

    assign push = IF_flag && !IQ_full;
    assign pop  = Dec_flag && IQ_flag;

    assign IQ_inst        = inst_mem[head];
    assign IQ_PC          = pc_mem[head];
    assign IQ_BTB_PC      = btb_pc_mem[head];
    assign IQ_BTB_predict = predict_mem[head];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (ROB_clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + ADDR_WIDTH'(1);
                end
                if (pop) begin
                    head <= head + ADDR_WIDTH'(1);
                end
                if (push && !pop) begin
                    count <= count + (ADDR_WIDTH+1)'(1);
                end else if (pop && !push) begin
                    count <= count - (ADDR_WIDTH+1)'(1);
                end
            end
        end
    end

    // Storage carries no reset; only entries between head and tail are ever presented.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && !ROB_clear && push) begin
            inst_mem[tail]    <= IF_inst;
            pc_mem[tail]      <= IF_PC;
            btb_pc_mem[tail]  <= IF_BTB_PC;
            predict_mem[tail] <= IF_BTB_predict;
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: the driver queues expected entries as it
// issues pushes, and a negedge monitor compares the presented head and pops on handshake.
module tb_instruction_queue;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] btb;
        logic        pred;
    } entry_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        IF_flag;
    logic [31:0] IF_inst;
    logic [31:0] IF_PC;
    logic [31:0] IF_BTB_PC;
    logic        IF_BTB_predict;
    logic        IQ_full;
    logic        IQ_flag;
    logic [31:0] IQ_inst;
    logic [31:0] IQ_PC;
    logic [31:0] IQ_BTB_PC;
    logic        IQ_BTB_predict;
    logic        Dec_flag;
    logic        ROB_clear;

    entry_t exp_q[$];
    bit     model_valid = 1'b0;
    int     n_checks = 0;
    int     n_pass   = 0;

    instruction_queue #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .IF_flag        (IF_flag),
        .IF_inst        (IF_inst),
        .IF_PC          (IF_PC),
        .IF_BTB_PC      (IF_BTB_PC),
        .IF_BTB_predict (IF_BTB_predict),
        .IQ_full        (IQ_full),
        .IQ_flag        (IQ_flag),
        .IQ_inst        (IQ_inst),
        .IQ_PC          (IQ_PC),
        .IQ_BTB_PC      (IQ_BTB_PC),
        .IQ_BTB_predict (IQ_BTB_predict),
        .Dec_flag       (Dec_flag),
        .ROB_clear      (ROB_clear)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are compared mid-cycle against the queued expectation.
    always @(negedge clk_in) begin
        if (model_valid) begin
            logic exp_flag;
            entry_t e;
            exp_flag = rdy_in && !ROB_clear && (exp_q.size() != 0);
            chk("IQ_full", {31'd0, IQ_full}, {31'd0, exp_q.size() == DEPTH});
            chk("IQ_flag", {31'd0, IQ_flag}, {31'd0, exp_flag});
            if (exp_flag) begin
                e = exp_q[0];
                chk("IQ_inst", IQ_inst, e.inst);
                chk("IQ_PC", IQ_PC, e.pc);
                chk("IQ_BTB_PC", IQ_BTB_PC, e.btb);
                chk("IQ_BTB_predict", {31'd0, IQ_BTB_predict}, {31'd0, e.pred});
                if (Dec_flag) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Advance one clock with the current inputs and record what the edge should do.
    task automatic tick();
        int     pre_size = exp_q.size();
        logic   r_rst    = rst_in;
        logic   r_rdy    = rdy_in;
        logic   r_clr    = ROB_clear;
        logic   r_if     = IF_flag;
        entry_t e        = '{inst: IF_inst, pc: IF_PC, btb: IF_BTB_PC, pred: IF_BTB_predict};
        @(posedge clk_in);
        #1;
        if (r_rst) begin
            exp_q.delete();
            model_valid = 1'b1;
        end else if (r_rdy) begin
            if (r_clr) begin
                exp_q.delete();
            end else if (r_if && pre_size < DEPTH) begin
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic f, input logic [31:0] pc, input logic d);
        IF_flag        = f;
        IF_PC          = pc;
        IF_inst        = pc + 32'h13;
        IF_BTB_PC      = pc + 32'h4;
        IF_BTB_predict = pc[2];
        Dec_flag       = d;
        tick();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; ROB_clear = 1'b0; Dec_flag = 1'b0;
        IF_flag = 1'b1; IF_inst = 32'h0; IF_PC = 32'h0; IF_BTB_PC = 32'h0; IF_BTB_predict = 1'b0;
        repeat (3) tick();
        rst_in = 1'b0; IF_flag = 1'b0;
        tick();

        // Single push then pop
        IF_flag = 1'b1; IF_inst = 32'h0050_0093; IF_PC = 32'h0; IF_BTB_PC = 32'h4; IF_BTB_predict = 1'b0;
        tick();
        IF_flag = 1'b0;
        tick();
        Dec_flag = 1'b1;
        tick();
        Dec_flag = 1'b0;
        tick();

        // Fill, rejected 17th push, drain in order
        for (int i = 0; i < 16; i++) drive(1'b1, 32'(i * 4), 1'b0);
        drive(1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);

        // Interleaved pushes and pops across the pointer wrap
        for (int i = 0; i < 20; i++) drive(1'b1, 32'h200 + 32'(i * 4), 1'(i % 2));
        for (int i = 0; i < 12; i++) drive(1'b0, 32'h0, 1'b1);

        // Push+pop at count 1
        drive(1'b1, 32'h300, 1'b0);
        for (int i = 1; i <= 3; i++) drive(1'b1, 32'h300 + 32'(i * 4), 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);

        // Push+pop at count 15, then at full (push rejected, pop accepted)
        for (int i = 0; i < 15; i++) drive(1'b1, 32'h400 + 32'(i * 4), 1'b0);
        drive(1'b1, 32'h480, 1'b1);
        drive(1'b1, 32'h484, 1'b1);
        drive(1'b1, 32'h488, 1'b0);
        drive(1'b1, 32'h48C, 1'b1);
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b0, 32'h0, 1'b1);

        // Flush with concurrent push and pop requests
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h600 + 32'(i * 4), 1'b0);
        ROB_clear = 1'b1;
        drive(1'b1, 32'h700, 1'b1);
        ROB_clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b1, 32'h100, 1'b0);
        drive(1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);

        // Global stall with 3 entries held
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 32'(i * 4), 1'b0);
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h800, 1'b1);
        rdy_in = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);
        drive(1'b0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
